sc_shift_sequencer: RTL
=======================

SC_SHIFT_SEQUENCER -- requirements
Module: sc_shift_sequencer

Interface
REQ-001 SHALL have parameter ShiftSEQ_DATAWIDTH, default 8, width of the data path to the shift register.
REQ-002 SHALL have parameter ShiftSEQ_COUNTWIDTH, default 4, width of the shift-count field.
REQ-003 SHALL have port SC_ShiftSEQ_CLOCK_50  in  1  system clock, all state updates on its rising edge.
REQ-004 SHALL have port SC_ShiftSEQ_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SC_ShiftSEQ_cmdValid_In  in  1  command present.
REQ-006 SHALL have port SC_ShiftSEQ_cmdReady_Out  out  1  block can accept a command.
REQ-007 SHALL have port SC_ShiftSEQ_cmdDir_In  in  1  0 = shift left, 1 = shift right.
REQ-008 SHALL have port SC_ShiftSEQ_cmdCount_In  in  COUNTWIDTH  number of single-bit shifts.
REQ-009 SHALL have port SC_ShiftSEQ_cmdData_InBUS  in  DATAWIDTH  value to load before shifting.
REQ-010 SHALL have port SC_ShiftSEQ_data_OutBUS  out  DATAWIDTH  load value driven to the downstream shift register.
REQ-011 SHALL have port SC_ShiftSEQ_load_OutLow  out  1  active-low load strobe to the downstream shift register.
REQ-012 SHALL have port SC_ShiftSEQ_shiftselection_Out  out  2  shift code: 00 hold, 01 left, 10 right; 11 never driven.
REQ-013 SHALL have port SC_ShiftSEQ_busy_Out  out  1  high in LOAD, SHIFT and DONE.
REQ-014 SHALL have port SC_ShiftSEQ_done_Out  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, LOAD, SHIFT and DONE; all outputs except cmdReady SHALL be registered.
REQ-016 SHALL drive cmdReady = 1 only in IDLE; a command SHALL be accepted on a rising edge with cmdValid = 1 and cmdReady = 1.
REQ-017 On acceptance, SHALL capture dir, count and data, and SHALL move IDLE -> LOAD.
REQ-018 In LOAD, SHALL drive load_OutLow = 0, data_OutBUS = the captured data and shiftselection = 00, for exactly one cycle.
REQ-019 From LOAD, SHALL go to SHIFT if count > 0, otherwise to DONE.
REQ-020 In SHIFT, SHALL drive load_OutLow = 1 and shiftselection = 01 (dir 0) or 10 (dir 1) for exactly count cycles, using a down-counter, then SHALL go to DONE.
REQ-021 In DONE, SHALL drive done_Out = 1 and shiftselection = 00 for one cycle, then SHALL return to IDLE.
REQ-022 The latency from the acceptance edge to done_Out high SHALL be count + 2 cycles; the minimum spacing between accepted commands SHALL be count + 3 cycles.
REQ-023 cmdValid, and any change to the command inputs, SHALL be ignored while cmdReady = 0.
REQ-024 A count >= DATAWIDTH SHALL be executed in full, with no saturation; the downstream register then ends at zero.
REQ-025 In IDLE, SHALL drive load_OutLow = 1, shiftselection = 00 and data_OutBUS = the last loaded value (0 after reset).

Reset
REQ-026 While RESET_InLow = 0, the block SHALL be in IDLE with the counter at 0, data_OutBUS = 0, load_OutLow = 1, shiftselection = 00, busy = 0, done = 0 and cmdReady = 1.
REQ-027 A reset asserted mid-operation SHALL abort immediately, with no done pulse; the first accept SHALL be possible on the first rising edge after deassertion.

Configuration
REQ-028 With SC_SHIFTSEQ_ABORT_EN defined, the block SHALL add port SC_ShiftSEQ_abort_In (in, 1).
REQ-029 With SC_SHIFTSEQ_ABORT_EN defined, abort_In = 1 in LOAD or SHIFT SHALL force DONE on the next edge, with shiftselection = 00 from that edge on.
REQ-030 Without SC_SHIFTSEQ_ABORT_EN, the port and its logic SHALL be absent, and behaviour SHALL be exactly as in REQ-015..REQ-027.

Structure
REQ-031 Package sc_shiftseq_pkg SHALL hold the state enum and the shiftselection constants SHIFT_HOLD = 2'b00, SHIFT_LEFT = 2'b01 and SHIFT_RIGHT = 2'b10.
REQ-032 The down-counter SHALL be the single sub-module sc_shiftseq_counter (load, decrement, zero flag).

Verification
REQ-033 Reset then dir = 0, count = 3, data = 8'h01 -> one LOAD cycle with data 8'h01, three cycles of code 01, done on edge +5; a downstream shifter model holds 8'h08.
REQ-034 dir = 1, count = 0, data = 8'hA5 -> LOAD, then DONE the next cycle with no 10 code; the model holds 8'hA5.
REQ-035 dir = 1, count = 15, data = 8'hFF -> 15 cycles of code 10; the model holds 8'h00; busy is high for 17 cycles.
REQ-036 cmdValid held high through a count = 2 command -> second command accepted only at the first IDLE cycle; ready is low for 4 cycles.
REQ-037 Reset pulsed low during the second SHIFT cycle of count = 5 -> outputs take reset values at once, no done pulse; a new command is accepted after release.
REQ-038 With SC_SHIFTSEQ_ABORT_EN defined: abort during SHIFT of count = 6 -> done on the next edge, and shiftselection = 00 from then on.

Source files
------------

// File: rtl/sc_shiftseq_pkg.sv
// sc_shiftseq_pkg -- shared types and constants for the shift sequencer.
// Holds the sequencer state encoding and the 2-bit shift-selection codes
// understood by the downstream shift register.
package sc_shiftseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } shiftseq_state_t;

    // Shift-selection codes; 2'b11 is never driven.
    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    // Map the command direction bit (0 = left, 1 = right) onto a shift code.
    function automatic logic [1:0] dirToCode(input logic dir);
        return dir ? SHIFT_RIGHT : SHIFT_LEFT;
    endfunction

endpackage

// File: rtl/sc_shiftseq_counter.sv
// sc_shiftseq_counter -- loadable down-counter with zero flag.
// Counts the remaining single-bit shifts of the current command.
// Decrement never wraps below zero.
module sc_shiftseq_counter #(
    parameter int CounterWIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [CounterWIDTH-1:0] loadValue,
    input  logic                    decrement,
    output logic [CounterWIDTH-1:0] count,
    output logic                    zero
);

    logic [CounterWIDTH-1:0] countReg;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (decrement && (countReg != '0)) begin
            countReg <= countReg - CounterWIDTH'(1);
        end
    end

    assign count = countReg;
    assign zero  = (countReg == '0);

endmodule

// File: rtl/sc_shift_sequencer.sv
// sc_shift_sequencer -- sequences a downstream shift register through
// LOAD, a counted run of single-bit shifts, and a DONE pulse.
// Optional feature: define SC_SHIFTSEQ_ABORT_EN to add SC_ShiftSEQ_abort_In,
// which forces DONE from LOAD or SHIFT and drops the shift code at once.
// All outputs except cmdReady are registered from the current state, so
// they trail the state register by one edge; cmdReady is decoded directly
// from the state so an accept can happen on the first edge in IDLE.
module sc_shift_sequencer
    import sc_shiftseq_pkg::*;
#(
    parameter int ShiftSEQ_DATAWIDTH  = 8,
    parameter int ShiftSEQ_COUNTWIDTH = 4
) (
    input  logic                           SC_ShiftSEQ_CLOCK_50,
    input  logic                           SC_ShiftSEQ_RESET_InLow,
    input  logic                           SC_ShiftSEQ_cmdValid_In,
    output logic                           SC_ShiftSEQ_cmdReady_Out,
    input  logic                           SC_ShiftSEQ_cmdDir_In,
    input  logic [ShiftSEQ_COUNTWIDTH-1:0] SC_ShiftSEQ_cmdCount_In,
    input  logic [ShiftSEQ_DATAWIDTH-1:0]  SC_ShiftSEQ_cmdData_InBUS,
    output logic [ShiftSEQ_DATAWIDTH-1:0]  SC_ShiftSEQ_data_OutBUS,
    output logic                           SC_ShiftSEQ_load_OutLow,
    output logic [1:0]                     SC_ShiftSEQ_shiftselection_Out,
    output logic                           SC_ShiftSEQ_busy_Out,
    output logic                           SC_ShiftSEQ_done_Out
`ifdef SC_SHIFTSEQ_ABORT_EN
    ,
    input  logic                           SC_ShiftSEQ_abort_In
`endif
);

    shiftseq_state_t                stateReg;
    logic                           dirReg;
    logic [ShiftSEQ_DATAWIDTH-1:0]  dataReg;
    logic [ShiftSEQ_DATAWIDTH-1:0]  dataOutReg;
    logic                           loadNReg;
    logic [1:0]                     selReg;
    logic                           busyReg;
    logic                           doneReg;

    logic                           acceptCmd;
    logic                           countDec;
    logic                           countLast;
    logic                           countZero;
    logic [ShiftSEQ_COUNTWIDTH-1:0] countValue;

    assign SC_ShiftSEQ_cmdReady_Out = (stateReg == ST_IDLE);
    assign acceptCmd = SC_ShiftSEQ_cmdValid_In && SC_ShiftSEQ_cmdReady_Out;
    assign countDec  = (stateReg == ST_SHIFT);
    // The shift now in progress is the last one of the command.
    assign countLast = (countValue == ShiftSEQ_COUNTWIDTH'(1));

`ifdef SC_SHIFTSEQ_ABORT_EN
    logic abortHit;
    assign abortHit = SC_ShiftSEQ_abort_In &&
                      ((stateReg == ST_LOAD) || (stateReg == ST_SHIFT));
`endif

    // The shift count is captured straight into the down-counter on accept.
    sc_shiftseq_counter #(
        .CounterWIDTH(ShiftSEQ_COUNTWIDTH)
    ) u_counter (
        .clk       (SC_ShiftSEQ_CLOCK_50),
        .rst_n     (SC_ShiftSEQ_RESET_InLow),
        .load      (acceptCmd),
        .loadValue (SC_ShiftSEQ_cmdCount_In),
        .decrement (countDec),
        .count     (countValue),
        .zero      (countZero)
    );

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge SC_ShiftSEQ_CLOCK_50 or negedge SC_ShiftSEQ_RESET_InLow) begin
        if (!SC_ShiftSEQ_RESET_InLow) begin
            stateReg   <= ST_IDLE;
            dirReg     <= 1'b0;
            dataReg    <= '0;
            dataOutReg <= '0;
            loadNReg   <= 1'b1;
            selReg     <= SHIFT_HOLD;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            // Outputs present the state held during the cycle just ended.
            loadNReg <= (stateReg != ST_LOAD);
            busyReg  <= (stateReg != ST_IDLE);
            doneReg  <= (stateReg == ST_DONE);
            selReg   <= (stateReg == ST_SHIFT) ? dirToCode(dirReg) : SHIFT_HOLD;
            if (stateReg == ST_LOAD) begin
                dataOutReg <= dataReg;
            end

            case (stateReg)
                ST_IDLE: begin
                    if (acceptCmd) begin
                        dirReg   <= SC_ShiftSEQ_cmdDir_In;
                        dataReg  <= SC_ShiftSEQ_cmdData_InBUS;
                        stateReg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    stateReg <= countZero ? ST_DONE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (countLast) begin
                        stateReg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    stateReg <= ST_IDLE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase

`ifdef SC_SHIFTSEQ_ABORT_EN
            // Abort overrides the normal transition and stops shifting now.
            if (abortHit) begin
                stateReg <= ST_DONE;
                selReg   <= SHIFT_HOLD;
            end
`endif
        end
    end

    assign SC_ShiftSEQ_data_OutBUS        = dataOutReg;
    assign SC_ShiftSEQ_load_OutLow        = loadNReg;
    assign SC_ShiftSEQ_shiftselection_Out = selReg;
    assign SC_ShiftSEQ_busy_Out           = busyReg;
    assign SC_ShiftSEQ_done_Out           = doneReg;

endmodule
